// File: rtl/sum_3_arb_pkg.sv
// Shared constants and types for the four-channel 3-sample moving-sum scheduler.
package sum_3_pkg;
    localparam int NUM_CH   = 4;
    localparam int SAMPLE_W = 8;
    localparam int SUM_W    = SAMPLE_W + 2;
    localparam int CH_W     = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SUM_W-1:0]    sum_t;
    typedef logic [1:0]                 cnt_t;

    localparam cnt_t CNT_MAX = 2'd2;
endpackage

// File: rtl/sum_3_arb_rr_arb4.sv
// Combinational 4-way round-robin arbiter: grants the first requester at or after ptr.
module rr_arb4
    import sum_3_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_id
);
    logic [CH_W-1:0] idx;
    logic            found;

    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        // Scan channels in priority order starting at ptr, wrapping modulo 4.
        for (int k = 0; k < NUM_CH; k++) begin
            idx = ptr + CH_W'(k);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_id   = idx;
                found    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sum_3_arb.sv
// Round-robin shared 3-sample moving-sum engine with per-channel 2-deep history
// and a single registered valid/ready output.
module sum_3_arb
    import sum_3_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] in_num,
    output logic [NUM_CH-1:0]          in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SUM_W-1:0]    out_sum,
    output logic [CH_W-1:0]            out_ch,
    output logic                       out_full
);
    // Range of three 8-bit samples is -384..381, so the 10-bit sum cannot wrap.
    function automatic sum_t sum3(sample_t a, sample_t b, sample_t c);
        return {{(SUM_W-SAMPLE_W){a[SAMPLE_W-1]}}, a}
             + {{(SUM_W-SAMPLE_W){b[SAMPLE_W-1]}}, b}
             + {{(SUM_W-SAMPLE_W){c[SAMPLE_W-1]}}, c};
    endfunction

    logic              free;
    logic              en;
    logic              acc;
    logic [NUM_CH-1:0] gnt;
    logic [CH_W-1:0]   gnt_id;
    logic [CH_W-1:0]   ptr;
    sample_t           cur;
    sample_t           h0 [NUM_CH];
    sample_t           h1 [NUM_CH];
    cnt_t              cnt [NUM_CH];

    assign free     = !out_valid || out_ready;
    assign en       = free && !clr && rst;
    assign in_ready = gnt;
    assign acc      = |gnt;
    assign cur      = in_num[gnt_id*SAMPLE_W +: SAMPLE_W];

    rr_arb4 u_arb (
        .req    (in_valid),
        .ptr    (ptr),
        .en     (en),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ch    <= '0;
            out_full  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                h0[i]  <= '0;
                h1[i]  <= '0;
                cnt[i] <= '0;
            end
        end else begin
            if (clr) begin
                ptr <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    h0[i]  <= '0;
                    h1[i]  <= '0;
                    cnt[i] <= '0;
                end
            end else if (acc) begin
                ptr         <= gnt_id + 2'd1;
                h0[gnt_id]  <= h1[gnt_id];
                h1[gnt_id]  <= cur;
                if (cnt[gnt_id] != CNT_MAX)
                    cnt[gnt_id] <= cnt[gnt_id] + 2'd1;
            end

            // Output register: a new accept overrides a same-cycle drain.
            if (acc) begin
                out_sum   <= sum3(cur, h1[gnt_id], h0[gnt_id]);
                out_ch    <= gnt_id;
                out_full  <= (cnt[gnt_id] == CNT_MAX);
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/sum_3_arb.md
# sum_3_arb

Round-robin scheduler that shares one 3-sample moving-sum engine between four sample requesters. It keeps a private 2-deep sample history per channel, so every channel's sums stay independent. It drives a single registered output with valid/ready backpressure. It sits between the sample sources and the moving-average consumer, and replaces per-channel `sum_3` instances.

## Interface
- `NUM_CH`, 4, number of requesters (fixed at 4 for this release; channel id is 2 bits)
- `SAMPLE_W`, 8, signed sample width
- `SUM_W`, 10, signed sum width (`SAMPLE_W`+2)

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `clr`  in  1  synchronous flush of all histories and warm-up counts
- `in_valid`  in  NUM_CH  per-channel sample request
- `in_num`  in  NUM_CH*SAMPLE_W  packed signed samples; channel i occupies bits [8i+7:8i]
- `in_ready`  out  NUM_CH  one-hot grant; a sample transfers when `in_valid[i] & in_ready[i]`
- `out_valid`  out  1  result register holds a sum
- `out_ready`  in  1  consumer accepts the result
- `out_sum`  out  SUM_W  signed sum of the current sample and the channel's two previous samples
- `out_ch`  out  2  channel that produced `out_sum`
- `out_full`  out  1  1 when all three terms are real samples; 0 during warm-up

## Operation
- Slot free: `free = !out_valid | out_ready`.
- Grant conditions:
  - `in_ready` is combinational: it is one-hot on the first requesting channel at or after the round-robin pointer `ptr`.
  - `in_ready` is all-zero when `!free`, when `clr = 1`, or when no channel requests.
- Pointer: after a grant to channel i, `ptr` becomes (i+1) mod 4. Without a grant, `ptr` holds.
- Accept on channel c:
  - `out_sum <= sext(in_num[c]) + sext(h1[c]) + sext(h0[c])`. Range is -384..381, so no overflow is possible.
  - `out_ch <= c`.
  - `out_full <= (cnt[c] == 2)`.
  - `out_valid <= 1`.
  - History shifts: `h0[c] <= h1[c]`, `h1[c] <= in_num[c]`.
  - `cnt[c]` increments, saturating at 2.
- Warm-up: empty history slots read as 0. The first two sums of a channel carry `out_full = 0`.
- Drain: if `out_valid & out_ready` and no new accept in the same cycle, `out_valid <= 0`. Data outputs hold their last values.
- Simultaneous drain and accept: the new result replaces the old one, and `out_valid` stays 1. This gives full throughput of one sample per cycle.
- `clr`:
  - All `h0`, `h1`, `cnt` become 0 and `ptr` becomes 0 on the next edge. There is no grant that cycle.
  - The output register is unaffected and drains normally.
- Non-granted channels: their history, counts and samples are untouched. Sources must hold `in_valid` and `in_num` until granted.

## Timing
- Latency: a sample accepted at edge N appears on `out_*` after edge N, with `out_valid = 1` in cycle N+1.
- Throughput: one accept per cycle while `out_ready = 1`.
- Backpressure: while `out_valid & !out_ready`, no grants are issued and `out_*` is stable.
- Starvation bound: a continuously requesting channel is granted within 4 accepts.
- Reset (rst low, asynchronous):
  - `out_valid = 0`, `out_sum = 0`, `out_ch = 0`, `out_full = 0`.
  - `ptr = 0`; all history and counts are 0.
  - `in_ready` is forced to 0 while `rst` is low.
- Reset mid-operation: a pending result is discarded and warm-up restarts for all channels.
- Release of reset: grants may start in the first cycle with `rst` high.

## Structure
- Shared package `sum_3_pkg`: `NUM_CH`, `SAMPLE_W`, `SUM_W`, `CH_W = 2`, `CNT_MAX = 2`.
- Sub-module `rr_arb4`: combinational 4-way round-robin grant from `req`, `ptr`, `en`; outputs one-hot `gnt` and encoded `gnt_id`.
- Top level holds the `ptr` register, the per-channel history/count arrays, the adder, and the output register.

## Test plan
- Warm-up, single channel: ch0 sends 2, 1, -1 back-to-back, out_ready=1 → sums 2, 3, 2 on consecutive cycles, `out_full` 0, 0, 1, `out_ch` = 0.
- Extremes: ch1 sends -128 ×3, then 127 ×3 → third sum -384 (`out_full` = 1), sixth sum 381; no wrap.
- Fairness: all four channels request continuously with distinct constants 1, 2, 3, 4 → grant order 0, 1, 2, 3, 0, …. On each channel's third grant, the sums are 3, 6, 9, 12.
- Backpressure: out_ready=0 for 3 cycles while a result is pending → `in_ready` = 0000 and `out_sum`/`out_ch` stable. Raising out_ready gives drain and the next accept in the same cycle.
- Isolation and clr: interleave ch2 (5, 5) and ch3 (-7), then pulse clr, then ch2 sends 5.
  - Before clr: ch3's sum is -7, and ch2's second sum is 10 (`out_full` = 0).
  - After clr: ch2's sum is 5 with `out_full` = 0.
- Async reset mid-stream: assert rst low between clock edges while out_valid=1 → outputs go to 0 immediately. After release, ch0 sending 4 yields 4 with `out_full` = 0.
